// File: rtl/esl_bus_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : esl_bus_copy_master
// Purpose  : Avalon-MM master block-copy engine. Copies `length` words from a
//            source word-address range to a destination range, one word at a
//            time: read a word, write it, repeat. Addresses wrap modulo
//            2**ADDR_WIDTH.
// Ports    : clk, reset (async, active-high)
//            start/src_addr/dst_addr/length : copy request, sampled in IDLE
//            busy/done/words_done           : progress to the local controller
//            master_*                       : Avalon-MM master port
// Revision : 1.0 - initial release
// ============================================================================
module esl_bus_copy_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   src_addr,
   input  logic [ADDR_WIDTH-1:0]   dst_addr,
   input  logic [LEN_WIDTH-1:0]    length,
   output logic                    busy,
   output logic                    done,
   output logic [LEN_WIDTH-1:0]    words_done,
   output logic [ADDR_WIDTH-1:0]   master_address,
   output logic                    master_read,
   output logic                    master_write,
   output logic [DATA_WIDTH-1:0]   master_writedata,
   output logic [DATA_WIDTH/8-1:0] master_byteenable,
   input  logic [DATA_WIDTH-1:0]   master_readdata,
   input  logic                    master_readdatavalid,
   input  logic                    master_waitrequest
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  src_q, src_d;
   logic [ADDR_WIDTH-1:0]  dst_q, dst_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   idx_q, idx_d;
   logic [LEN_WIDTH-1:0]   words_done_q, words_done_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   read_q, read_d;
   logic                   write_q, write_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [BE_WIDTH-1:0]    be_q, be_d;
   logic [LEN_WIDTH-1:0]   w_idx_inc;
   logic [ADDR_WIDTH-1:0]  w_idx_addr;

   // State register and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         words_done_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         addr_q       <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         be_q         <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         words_done_q <= words_done_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         addr_q       <= addr_d;
         read_q       <= read_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;
      idx_d        = idx_q;
      words_done_d = words_done_q;
      wdata_d      = wdata_q;
      addr_d       = addr_q;
      done_d       = 1'b0;
      w_idx_inc    = idx_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d        = src_addr;
               dst_d        = dst_addr;
               len_d        = length;
               idx_d        = '0;
               words_done_d = '0;
               state_d      = (length == '0) ? S_FIN : S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (!master_waitrequest) begin
               // Zero-latency slaves return data in the accept cycle
               if (master_readdatavalid) begin
                  wdata_d = master_readdata;
                  state_d = S_WR_REQ;
               end else begin
                  state_d = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (master_readdatavalid) begin
               wdata_d = master_readdata;
               state_d = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (!master_waitrequest) begin
               words_done_d = w_idx_inc;
               if (w_idx_inc == len_q) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = w_idx_inc;
                  state_d = S_RD_REQ;
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Bus outputs are registered, so they are derived from the next state;
      // while stalled the next state equals the current one and they hold.
      w_idx_addr = ADDR_WIDTH'(idx_d);
      read_d     = (state_d == S_RD_REQ);
      write_d    = (state_d == S_WR_REQ);
      be_d       = (read_d || write_d) ? {BE_WIDTH{1'b1}} : {BE_WIDTH{1'b0}};
      if (read_d) begin
         addr_d = src_d + w_idx_addr;
      end else if (write_d) begin
         addr_d = dst_d + w_idx_addr;
      end
      // FIN always steps to IDLE, so busy drops in the done cycle
      busy_d = (state_d != S_IDLE);
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign words_done        = words_done_q;
   assign master_address    = addr_q;
   assign master_read       = read_q;
   assign master_write      = write_q;
   assign master_writedata  = wdata_q;
   assign master_byteenable = be_q;

endmodule
`default_nettype wire

// File: tb/tb_esl_bus_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_esl_bus_copy_master
// Purpose  : Directed self-checking bench for esl_bus_copy_master with an
//            Avalon-MM slave memory model (configurable stall and latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_esl_bus_copy_master;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  src_addr = '0;
   logic [7:0]  dst_addr = '0;
   logic [7:0]  length = '0;
   logic        busy, done;
   logic [7:0]  words_done;
   logic [7:0]  master_address;
   logic        master_read, master_write;
   logic [31:0] master_writedata;
   logic [3:0]  master_byteenable;
   logic [31:0] master_readdata = '0;
   logic        master_readdatavalid = 1'b0;
   logic        master_waitrequest = 1'b0;

   esl_bus_copy_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
      .clk                  (clk),
      .reset                (reset),
      .start                (start),
      .src_addr             (src_addr),
      .dst_addr             (dst_addr),
      .length               (length),
      .busy                 (busy),
      .done                 (done),
      .words_done           (words_done),
      .master_address       (master_address),
      .master_read          (master_read),
      .master_write         (master_write),
      .master_writedata     (master_writedata),
      .master_byteenable    (master_byteenable),
      .master_readdata      (master_readdata),
      .master_readdatavalid (master_readdatavalid),
      .master_waitrequest   (master_waitrequest)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Slave model state
   logic [31:0] mem [0:255];
   int          wait_cfg = 0;
   int          lat_cfg  = 1;
   int          stall_cnt = 0;
   int          rd_cd = 0;
   logic [31:0] rd_data = '0;
   logic        prev_stall = 1'b0;
   logic [41:0] prev_bus = '0;
   int          done_cnt = 0;
   int          req_cnt = 0;
   logic [7:0]  rd_log [$];
   logic [7:0]  wr_log [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Avalon slave: reacts at the falling edge to the request registered at
   // the preceding rising edge.
   initial begin
      forever begin
         @(negedge clk);
         master_readdatavalid = 1'b0;
         master_waitrequest   = 1'b0;
         master_readdata      = 32'hBADD_0000;
         if (reset) begin
            stall_cnt  = 0;
            rd_cd      = 0;
            prev_stall = 1'b0;
         end else begin
            if (done === 1'b1) done_cnt++;
            chk("byteenable", {28'd0, master_byteenable},
                (master_read || master_write) ? 32'hF : 32'h0);
            chk("rd_wr_exclusive", {31'd0, master_read && master_write}, 32'd0);
            if (prev_stall) begin
               checks++;
               assert ({master_read, master_write, master_address, master_writedata} === prev_bus) else begin
                  errors++;
                  $error("FAIL stall_hold observed=%0h expected=%0h",
                         {master_read, master_write, master_address, master_writedata}, prev_bus);
               end
            end
            if (rd_cd > 0) begin
               rd_cd--;
               if (rd_cd == 0) begin
                  master_readdatavalid = 1'b1;
                  master_readdata      = rd_data;
               end
            end
            if (master_read || master_write) begin
               req_cnt++;
               if (stall_cnt < wait_cfg) begin
                  master_waitrequest = 1'b1;
                  stall_cnt++;
               end else begin
                  stall_cnt = 0;
                  if (master_write) begin
                     mem[master_address] = master_writedata;
                     wr_log.push_back(master_address);
                  end else begin
                     rd_log.push_back(master_address);
                     if (lat_cfg == 0) begin
                        master_readdatavalid = 1'b1;
                        master_readdata      = mem[master_address];
                     end else begin
                        rd_cd   = lat_cfg;
                        rd_data = mem[master_address];
                     end
                  end
               end
            end
            prev_stall = master_waitrequest;
            prev_bus   = {master_read, master_write, master_address, master_writedata};
         end
      end
   end

   task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
      @(negedge clk);
      start = 1'b1; src_addr = s; dst_addr = d; length = l;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input int max_cyc, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
      chk({tag, "_done"},  {31'd0, done}, 32'd0);
      chk({tag, "_read"},  {31'd0, master_read}, 32'd0);
      chk({tag, "_write"}, {31'd0, master_write}, 32'd0);
      chk({tag, "_addr"},  {24'd0, master_address}, 32'd0);
      chk({tag, "_wdata"}, master_writedata, 32'd0);
      chk({tag, "_be"},    {28'd0, master_byteenable}, 32'd0);
      chk({tag, "_wdone"}, {24'd0, words_done}, 32'd0);
   endtask

   initial begin
      int cyc;
      int dc;
      int rc;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: basic copy, zero wait, 1-cycle latency, 3 cycles per word
      mem[8'h10] = 32'hAAAA_0001; mem[8'h11] = 32'hBBBB_0002;
      mem[8'h12] = 32'hCCCC_0003; mem[8'h13] = 32'hDDDD_0004;
      wait_cfg = 0; lat_cfg = 1;
      dc = done_cnt;
      start_copy(8'h10, 8'h40, 8'd4);
      wait_done(100, cyc);
      chk("t1_cycles", cyc, 32'd13);
      chk("t1_words_done", {24'd0, words_done}, 32'd4);
      chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
      chk("t1_done_pulses", done_cnt - dc, 32'd1);
      chk("t1_mem40", mem[8'h40], 32'hAAAA_0001);
      chk("t1_mem41", mem[8'h41], 32'hBBBB_0002);
      chk("t1_mem42", mem[8'h42], 32'hCCCC_0003);
      chk("t1_mem43", mem[8'h43], 32'hDDDD_0004);
      @(negedge clk);
      chk("t1_done_single", {31'd0, done}, 32'd0);

      // 2: zero length
      repeat (2) @(negedge clk);
      #1 rc = req_cnt;
      start_copy(8'h10, 8'h50, 8'd0);
      chk("t2_done_early", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_busy", {31'd0, busy}, 32'd0);
      chk("t2_words_done", {24'd0, words_done}, 32'd0);
      repeat (2) @(negedge clk);
      #1 chk("t2_no_requests", req_cnt - rc, 32'd0);
      chk("t2_mem50", mem[8'h50], 32'd0);

      // 3: stalls of 5 cycles, read latency 3
      mem[8'h20] = 32'h1234_5678; mem[8'h21] = 32'h9ABC_DEF0; mem[8'h22] = 32'h0F0F_F0F0;
      wait_cfg = 5; lat_cfg = 3;
      start_copy(8'h20, 8'h60, 8'd3);
      wait_done(300, cyc);
      chk("t3_words_done", {24'd0, words_done}, 32'd3);
      chk("t3_mem60", mem[8'h60], 32'h1234_5678);
      chk("t3_mem61", mem[8'h61], 32'h9ABC_DEF0);
      chk("t3_mem62", mem[8'h62], 32'h0F0F_F0F0);

      // 4: address wrap with overlapping ranges (ascending order)
      mem[8'hFE] = 32'hFEFE_0000; mem[8'hFF] = 32'hFFFF_0000;
      mem[8'h00] = 32'h0000_1111; mem[8'h01] = 32'h0101_1111;
      wait_cfg = 0; lat_cfg = 1;
      rd_log.delete(); wr_log.delete();
      start_copy(8'hFE, 8'h00, 8'd4);
      wait_done(100, cyc);
      chk("t4_rd_count", rd_log.size(), 32'd4);
      chk("t4_wr_count", wr_log.size(), 32'd4);
      if (rd_log.size() == 4 && wr_log.size() == 4) begin
         chk("t4_rd0", {24'd0, rd_log[0]}, 32'hFE);
         chk("t4_rd1", {24'd0, rd_log[1]}, 32'hFF);
         chk("t4_rd2", {24'd0, rd_log[2]}, 32'h00);
         chk("t4_rd3", {24'd0, rd_log[3]}, 32'h01);
         chk("t4_wr0", {24'd0, wr_log[0]}, 32'h00);
         chk("t4_wr3", {24'd0, wr_log[3]}, 32'h03);
      end
      chk("t4_mem00", mem[8'h00], 32'hFEFE_0000);
      chk("t4_mem01", mem[8'h01], 32'hFFFF_0000);
      chk("t4_mem02", mem[8'h02], 32'hFEFE_0000);
      chk("t4_mem03", mem[8'h03], 32'hFFFF_0000);

      // 5: zero-latency slave, 2 cycles per word
      mem[8'h80] = 32'h5555_0001; mem[8'h81] = 32'h5555_0002; mem[8'h82] = 32'h5555_0003;
      wait_cfg = 0; lat_cfg = 0;
      start_copy(8'h80, 8'h90, 8'd3);
      wait_done(100, cyc);
      chk("t5_cycles", cyc, 32'd7);
      chk("t5_mem90", mem[8'h90], 32'h5555_0001);
      chk("t5_mem91", mem[8'h91], 32'h5555_0002);
      chk("t5_mem92", mem[8'h92], 32'h5555_0003);

      // 6: asynchronous reset during the stalled write of word index 2
      for (int i = 0; i < 6; i++) mem[8'hA0 + i] = 32'hA000_0000 + i;
      wait_cfg = 5; lat_cfg = 1;
      start_copy(8'hA0, 8'hC0, 8'd6);
      cyc = 0;
      while (!(master_write === 1'b1 && master_address === 8'hC2) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk("t6_reached_write2", {31'd0, master_write}, 32'd1);
      #1 dc = done_cnt;
      #1 reset = 1'b1;
      #1 check_idle_outputs("t6_async_reset");
      repeat (3) @(negedge clk);
      #1 chk("t6_no_done", done_cnt - dc, 32'd0);
      chk("t6_memC1", mem[8'hC1], 32'hA000_0001);
      chk("t6_memC2", mem[8'hC2], 32'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_cfg = 0; lat_cfg = 1;
      wr_log.delete();
      start_copy(8'hA0, 8'hD0, 8'd2);
      start = 1'b1; src_addr = 8'h00; dst_addr = 8'hE0; length = 8'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done(100, cyc);
      chk("t6_words_done", {24'd0, words_done}, 32'd2);
      chk("t6_wr_count", wr_log.size(), 32'd2);
      chk("t6_memD0", mem[8'hD0], 32'hA000_0000);
      chk("t6_memD1", mem[8'hD1], 32'hA000_0001);
      chk("t6_memE0", mem[8'hE0], 32'd0);
      chk("t6_done_pulse", done_cnt - dc, 32'd1);
      repeat (3) @(negedge clk);
      chk("t6_idle_busy", {31'd0, busy}, 32'd0);
      chk("t6_idle_read", {31'd0, master_read}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
